// File: rtl/nn_pkg.sv
// Shared constants and types for the MNIST front end.
// Holds frame geometry, the pixel-binarizer state encoding and the
// thresholding helper used by pixel_binarizer.
package nn_pkg;

    // Frame geometry: one 28x28 grayscale image per frame.
    localparam int NUM_PIXELS = 784;
    localparam int PIX_W      = 8;
    localparam int IDX_W      = 10;

    // Width of the optional set-bit count; wide enough for NUM_PIXELS.
    localparam int ONES_W     = 10;

    // Index of the final pixel of a well-formed frame.
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PIXELS - 1);

    // Binarizer control states.
    typedef enum logic [1:0] {
        FILL   = 2'd0,  // accepting pixels into the shadow frame
        COMMIT = 2'd1,  // complete frame waiting to be published
        DROP   = 2'd2   // discarding the tail of an over-long frame
    } binarizer_state_t;

    // Unsigned threshold compare: a pixel at or above the threshold is a 1.
    function automatic logic binarize(input logic [PIX_W-1:0] pix,
                                      input logic [PIX_W-1:0] thr);
        return (pix >= thr);
    endfunction

endpackage : nn_pkg

// File: rtl/pixel_binarizer_if.sv
// Pixel stream and feature-vector bundle for pixel_binarizer.
// The slave modport is the binarizer; the master modport is whoever
// sources pixels and consumes the committed feature vector.
// Optional macro PIXEL_BINARIZER_POPCOUNT_EN adds the ones_count signal.
interface pixel_binarizer_if;
    import nn_pkg::*;

    // Pixel stream (valid/ready) and threshold.
    logic [PIX_W-1:0]      thr;
    logic                  pix_valid;
    logic [PIX_W-1:0]      pix_data;
    logic                  pix_last;
    logic                  pix_ready;

    // Committed feature vector towards the classifier.
    logic                  feat_hold;
    logic [NUM_PIXELS-1:0] features;
    logic                  feat_valid;
    logic                  frame_err;

`ifdef PIXEL_BINARIZER_POPCOUNT_EN
    logic [ONES_W-1:0]     ones_count;

    modport slave (
        input  thr, pix_valid, pix_data, pix_last, feat_hold,
        output pix_ready, features, feat_valid, frame_err, ones_count
    );

    modport master (
        output thr, pix_valid, pix_data, pix_last, feat_hold,
        input  pix_ready, features, feat_valid, frame_err, ones_count
    );
`else
    modport slave (
        input  thr, pix_valid, pix_data, pix_last, feat_hold,
        output pix_ready, features, feat_valid, frame_err
    );

    modport master (
        output thr, pix_valid, pix_data, pix_last, feat_hold,
        input  pix_ready, features, feat_valid, frame_err
    );
`endif

endinterface : pixel_binarizer_if

// File: rtl/pixel_binarizer.sv
// pixel_binarizer: thresholds a valid/ready stream of grayscale pixels to
// one bit each, assembles a full frame in a private shadow register and
// publishes it atomically on the held features vector. Frames of the
// wrong length are discarded and flagged with a frame_err pulse; the last
// good vector stays put.
// Optional macro PIXEL_BINARIZER_POPCOUNT_EN adds a committed count of
// set bits (ones_count) alongside the features vector.
module pixel_binarizer
    import nn_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    pixel_binarizer_if.slave   pix_if
);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    binarizer_state_t      r_state;
    binarizer_state_t      w_state_nxt;

    logic [IDX_W-1:0]      r_idx;
    logic [PIX_W-1:0]      r_thr_q;
    logic [NUM_PIXELS-1:0] r_shadow;
    logic [NUM_PIXELS-1:0] r_features;
    logic                  r_feat_valid;
    logic                  r_frame_err;

    // ------------------------------------------------------------------
    // Control decode (driven by the next-state process)
    // ------------------------------------------------------------------
    logic                  w_ready;
    logic                  w_accept;
    logic                  w_idx_zero;
    logic                  w_idx_end;
    logic                  w_shadow_wr;  // accepted pixel lands in the shadow frame
    logic                  w_idx_inc;
    logic                  w_idx_clr;
    logic                  w_err_set;    // short frame or start of a long frame
    logic                  w_commit;     // publish shadow to features this edge

    // Thresholding and per-bit write enables
    logic [PIX_W-1:0]      w_thr_eff;
    logic                  w_bit;
    logic [NUM_PIXELS-1:0] w_shadow_we;

    // Ready is a pure decode of the state register, so there is no
    // combinational path from pix_valid back to pix_ready.
    assign w_ready    = (r_state != COMMIT);
    assign w_accept   = pix_if.pix_valid && w_ready;
    assign w_idx_zero = (r_idx == '0);
    assign w_idx_end  = (r_idx == LAST_IDX);

    // The first pixel of a frame is compared against the live threshold;
    // the rest use the copy latched on that first pixel, so a threshold
    // change mid-frame never splits a frame across two thresholds.
    assign w_thr_eff  = w_idx_zero ? pix_if.thr : r_thr_q;
    assign w_bit      = binarize(pix_if.pix_data, w_thr_eff);

    // State register
    // NOTE: sequential state is updated with non-blocking assignments so
    // every register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and control decode
    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave a latch behind.
    always_comb begin
        w_state_nxt = r_state;
        w_shadow_wr = 1'b0;
        w_idx_inc   = 1'b0;
        w_idx_clr   = 1'b0;
        w_err_set   = 1'b0;
        w_commit    = 1'b0;

        unique case (r_state)
            FILL: begin
                if (w_accept) begin
                    w_shadow_wr = 1'b1;
                    if (pix_if.pix_last) begin
                        if (w_idx_end) begin
                            // Exactly NUM_PIXELS pixels: frame is complete.
                            w_state_nxt = COMMIT;
                        end else begin
                            // Short frame: flag it and restart at pixel 0.
                            w_err_set = 1'b1;
                            w_idx_clr = 1'b1;
                        end
                    end else if (w_idx_end) begin
                        // Frame ran past NUM_PIXELS: flag once, then swallow
                        // the rest of it up to its pix_last.
                        w_err_set   = 1'b1;
                        w_idx_clr   = 1'b1;
                        w_state_nxt = DROP;
                    end else begin
                        w_idx_inc = 1'b1;
                    end
                end
            end

            COMMIT: begin
                // Stream is back-pressured here; the consumer may hold off
                // the update for as long as it needs a stable vector.
                if (!pix_if.feat_hold) begin
                    w_commit    = 1'b1;
                    w_idx_clr   = 1'b1;
                    w_state_nxt = FILL;
                end
            end

            DROP: begin
                if (w_accept && pix_if.pix_last) begin
                    w_idx_clr   = 1'b1;
                    w_state_nxt = FILL;
                end
            end

            default: begin
                w_state_nxt = FILL;
                w_idx_clr   = 1'b1;
            end
        endcase
    end

    // One-hot write enable: only the shadow bit addressed by the pixel
    // index is written on an accepted FILL pixel.
    always_comb begin
        w_shadow_we = '0;
        if (w_shadow_wr) begin
            w_shadow_we[r_idx] = 1'b1;
        end
    end

    // Pixel index counter and latched threshold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx   <= '0;
            r_thr_q <= '0;
        end else begin
            if (w_idx_clr) begin
                r_idx <= '0;
            end else if (w_idx_inc) begin
                r_idx <= r_idx + IDX_W'(1);
            end

            if (w_shadow_wr && w_idx_zero) begin
                r_thr_q <= pix_if.thr;
            end
        end
    end

    // Shadow frame: bits are overwritten in place as pixels arrive. A full
    // frame rewrites every bit, so no clear is needed between frames.
    // NOTE: the shadow is flop-based and is reset like any other register;
    // a RAM-style array would not take an asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shadow <= '0;
        end else begin
            for (int k = 0; k < NUM_PIXELS; k++) begin
                if (w_shadow_we[k]) begin
                    r_shadow[k] <= w_bit;
                end
            end
        end
    end

    // Committed vector and the registered status pulses. feat_valid comes
    // only from COMMIT and frame_err only from FILL, so they never overlap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_features   <= '0;
            r_feat_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            if (w_commit) begin
                r_features <= r_shadow;
            end
            r_feat_valid <= w_commit;
            r_frame_err  <= w_err_set;
        end
    end

    assign pix_if.pix_ready  = w_ready;
    assign pix_if.features   = r_features;
    assign pix_if.feat_valid = r_feat_valid;
    assign pix_if.frame_err  = r_frame_err;

`ifdef PIXEL_BINARIZER_POPCOUNT_EN
    logic [ONES_W-1:0] r_ones;
    logic [ONES_W-1:0] r_ones_q;
    logic [ONES_W-1:0] w_ones_base;

    // Pixel 0 starts a fresh count; later pixels add onto the running one.
    assign w_ones_base = w_idx_zero ? '0 : r_ones;

    // Running set-bit count of the shadow frame, published with features.
    // Any error (short frame or entry into DROP) throws the count away.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ones   <= '0;
            r_ones_q <= '0;
        end else begin
            if (w_err_set) begin
                r_ones <= '0;
            end else if (w_shadow_wr) begin
                r_ones <= w_ones_base + ONES_W'(w_bit);
            end

            if (w_commit) begin
                r_ones_q <= r_ones;
            end
        end
    end

    assign pix_if.ones_count = r_ones_q;
`endif

endmodule : pixel_binarizer

// File: doc/pixel_binarizer.md
# pixel_binarizer

- Upstream front end of the MNIST classifier.
- Accepts a valid/ready stream of 8-bit grayscale pixels, one per cycle, and thresholds each pixel to one bit.
- Assembles a 784-bit frame in a shadow register, then commits it atomically to a held `features` vector that drives the classifier's `features` input.
- Malformed frames (wrong length) are detected and discarded; the last good vector stays stable.

## Interface
- `NUM_PIXELS`, 784: pixels per frame; width of `features`.
- `PIX_W`, 8: pixel width, unsigned.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `thr`  in  PIX_W  binarization threshold; sampled on the first accepted pixel of each frame.
- `pix_valid`  in  1  pixel present.
- `pix_data`  in  PIX_W  pixel value.
- `pix_last`  in  1  marks final pixel of a frame; qualified by `pix_valid`.
- `pix_ready`  out  1  block accepts a pixel this cycle.
- `feat_hold`  in  1  consumer requests committed vector not change.
- `features`  out  NUM_PIXELS  committed binary frame; bit k = pixel k (first pixel = bit 0).
- `feat_valid`  out  1  one-cycle pulse on the cycle `features` first shows a new frame.
- `frame_err`  out  1  one-cycle pulse when a frame is discarded.

## Operation
- Handshake: a pixel is accepted on a rising edge where `pix_valid && pix_ready`.
- The pixel index counter (10 bits, 0..NUM_PIXELS-1) advances only on acceptance.
- Binarization: bit = (`pix_data` >= threshold), unsigned compare.
  - Index 0 uses `thr` directly and latches it into `thr_q`.
  - Indices 1..NUM_PIXELS-1 use `thr_q`.
- The bit is written into shadow bit [index]. The shadow register is never visible on the outputs.
- State FILL: `pix_ready`=1.
  - Accept with `pix_last`=1 and index == NUM_PIXELS-1 → COMMIT.
  - Accept with `pix_last`=1 and index != NUM_PIXELS-1 → pulse `frame_err`, index←0, stay FILL (short frame).
  - Accept with index == NUM_PIXELS-1 and `pix_last`=0 → pulse `frame_err`, → DROP (long frame).
- State COMMIT: `pix_ready`=0.
  - `feat_hold`=0 → `features`←shadow, `feat_valid`=1 next cycle, index←0, → FILL.
  - `feat_hold`=1 → remain in COMMIT; the stream is back-pressured.
- State DROP: `pix_ready`=1. Accepted pixels are discarded. Accepting a pixel with `pix_last`=1 → index←0, → FILL. No further `frame_err` is raised.
- `features` changes only on a COMMIT→FILL transition; otherwise it holds.
- Reset: state FILL, index 0, `thr_q` 0, shadow 0, `features` 0, `feat_valid` 0, `frame_err` 0, `pix_ready` 1 once `rst` deasserts.
- Reset mid-frame or in COMMIT: the partial or pending frame is lost, with no `frame_err`.

## Timing
- `pix_ready` is a combinational decode of the state register only. There is no path from `pix_valid`.
- Throughput: NUM_PIXELS+1 cycles per frame minimum (one COMMIT bubble).
- Latency: last pixel accepted at edge E → `features` updated and `feat_valid`=1 after edge E+1, when `feat_hold`=0 during the COMMIT cycle.
- Each cycle `feat_hold` stays high adds one cycle of latency.
- `frame_err` is registered and goes high after the edge that accepts the offending pixel.
- `feat_valid` and `frame_err` are never high in the same cycle.

## Configuration
- `PIXEL_BINARIZER_POPCOUNT_EN` defined:
  - Extra output `ones_count` [9:0].
  - An incrementing counter tracks set bits in the shadow frame.
  - The count is committed alongside `features` on the same edge.
  - Reset value 0. It is cleared at frame start, on a short frame and on DROP entry.
- Not defined: port and counter are absent; behaviour is otherwise identical.

## Structure
- Shared package `nn_pkg`:
  - `NUM_PIXELS`, `PIX_W`, `IDX_W`=10 constants.
  - `binarizer_state_t` enum {FILL, COMMIT, DROP}.
- Sub-module: none; thresholding is one compare, kept inline.
- The shadow register uses an index-decoded write enable per bit.

## Test plan
- Reset, then stream 784 pixels: value 200 at even indices, 50 at odd, `thr`=128, `pix_last` on index 783 → one `feat_valid` pulse; `features` = 0x...5555 (bit k=1 for even k); `frame_err` never high.
- Frame with `thr`=100 on first pixel, then `thr` changed to 250 mid-frame; all pixels 180 → `features` all ones (threshold latched at index 0).
- Short frame: `pix_last` at index 9 → `frame_err` pulse; `features` unchanged; next 784-pixel frame commits normally.
- Long frame: 784 pixels without `pix_last`, then 5 more with `pix_last` on the 5th → single `frame_err` pulse, DROP until the 5th, then a good frame commits.
- Hold `feat_hold`=1 for 6 cycles at COMMIT → `pix_ready`=0 for 6+1 cycles, `features` stable, `feat_valid` on the cycle after `feat_hold` falls.
- Assert `rst` at pixel 400 → all outputs 0 within the reset cycle, no `feat_valid`/`frame_err`; next full frame commits with index starting at 0.
